// File: rtl/sint_out_rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// sint_out_rr_arb_pkg
// Shared ray-tracer definitions used by the scene-intersection output merge:
//   pixel_buffer_entry_t  - entry format written into the pixel-buffer FIFO
//   NUM_PIXELS_DEFAULT    - writes per frame (640x480)
//   CNT_W_DEFAULT         - frame counter width (2^19 >= 307200)
//   SRC_TF/SRC_SSF/SRC_SSH- source indices on the merge arbiter
//   rr_add / rr_next      - modulo-3 index helpers for rotating selection
// ---------------------------------------------------------------------------
package sint_out_rr_arb_pkg;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] rgb;
  } pixel_buffer_entry_t;

  localparam int NUM_PIXELS_DEFAULT = 307200;
  localparam int CNT_W_DEFAULT      = 19;
  localparam int NUM_SRC            = 3;

  localparam logic [1:0] SRC_TF  = 2'd0;
  localparam logic [1:0] SRC_SSF = 2'd1;
  localparam logic [1:0] SRC_SSH = 2'd2;

  // (base + ofs) mod 3. A base of 3 (never produced by rr_next) still folds
  // back into 0..2 so a corrupted pointer cannot select a non-existent source.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] ofs);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, ofs};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

  // Pointer position just after the given source, wrapping 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == SRC_SSH) ? SRC_TF : idx + 2'd1;
  endfunction

endpackage

// File: rtl/sint_out_rr_arb_if.sv
// ---------------------------------------------------------------------------
// sint_out_rr_arb_if
// Bundles the three source streams and the pixel-buffer write port.
//   src_valid/src_data/src_stall : per-source handshake (bit 0 tf, 1 ssf, 2 ssh)
//   pb_full/pb_we/pb_data        : pixel-buffer FIFO write port
//   grant                        : source written this cycle (valid with pb_we)
//   frame_done/pix_count         : frame progress towards the camera controller
// modport master : the arbiter side
// modport slave  : the environment (sources + FIFO + frame handler)
// ---------------------------------------------------------------------------
interface sint_out_rr_arb_if #(
  parameter int DATA_W = $bits(sint_out_rr_arb_pkg::pixel_buffer_entry_t),
  parameter int CNT_W  = sint_out_rr_arb_pkg::CNT_W_DEFAULT
);

  logic [2:0]             src_valid;
  logic [2:0][DATA_W-1:0] src_data;
  logic [2:0]             src_stall;
  logic                   pb_full;
  logic                   pb_we;
  logic [DATA_W-1:0]      pb_data;
  logic [1:0]             grant;
  logic                   frame_done;
  logic [CNT_W-1:0]       pix_count;

  modport master (
    input  src_valid, src_data, pb_full,
    output src_stall, pb_we, pb_data, grant, frame_done, pix_count
  );

  modport slave (
    output src_valid, src_data, pb_full,
    input  src_stall, pb_we, pb_data, grant, frame_done, pix_count
  );

endinterface

// File: rtl/sint_out_rr_arb_rr_sel3.sv
// ---------------------------------------------------------------------------
// rr_sel3
// Combinational 3-way rotating priority select: returns the first requesting
// index found when scanning upward (mod 3) from ptr_i.
//   req_i [2:0] : request mask
//   ptr_i [1:0] : highest-priority index
//   idx_o [1:0] : selected index (0 when nothing requests)
//   any_o       : at least one request present
// ---------------------------------------------------------------------------
module rr_sel3
  import sint_out_rr_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] idx_o,
  output logic       any_o
);

  // cand[k] is the index examined at priority rank k.
  logic [1:0] cand [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    assign cand[gi] = rr_add(ptr_i, 2'(gi));
  end

  always_comb begin
    idx_o = 2'd0;
    any_o = 1'b0;
    if (req_i[cand[0]]) begin
      idx_o = cand[0];
      any_o = 1'b1;
    end else if (req_i[cand[1]]) begin
      idx_o = cand[1];
      any_o = 1'b1;
    end else if (req_i[cand[2]]) begin
      idx_o = cand[2];
      any_o = 1'b1;
    end
  end

endmodule

// File: rtl/sint_out_rr_arb.sv
// ---------------------------------------------------------------------------
// sint_out_rr_arb
// Merges the tf, ssf and ssh scene-intersection streams into the single
// pixel-buffer FIFO write port. Each source owns a one-entry holding register;
// full holds are drained in round-robin order whenever the FIFO is not full.
// A per-frame write counter pulses frame_done on the last write of a frame.
//   clk   : system clock
//   rst_b : asynchronous active-low reset (clears holds, pointer, count)
//   bus   : sint_out_rr_arb_if.master (source handshakes, FIFO port, frame)
// Parameters: DATA_W payload width, NUM_PIXELS writes per frame,
//             CNT_W counter width (2^CNT_W must be >= NUM_PIXELS).
// ---------------------------------------------------------------------------
module sint_out_rr_arb
  import sint_out_rr_arb_pkg::*;
#(
  parameter int DATA_W     = $bits(pixel_buffer_entry_t),
  parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input logic               clk,
  input logic               rst_b,
  sint_out_rr_arb_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

  logic [DATA_W-1:0] hold_data_q [NUM_SRC];
  logic [2:0]        hold_v_q, hold_v_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  pix_count_q, pix_count_d;

  logic [1:0]        sel_idx;
  logic              sel_any;
  logic              pb_we;
  logic [1:0]        grant;
  logic              frame_done;
  logic [DATA_W-1:0] pb_data;
  logic [2:0]        drain;
  logic [2:0]        stall;
  logic [2:0]        xfer;

  // ---- arbitration -------------------------------------------------------
  rr_sel3 u_sel (
    .req_i (hold_v_q),
    .ptr_i (rr_ptr_q),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  // pb_full gates the write combinationally so the FIFO never sees a write
  // while full.
  assign pb_we = sel_any & ~bus.pb_full;
  assign grant = pb_we ? sel_idx : 2'd0;

  always_comb begin
    pb_data = hold_data_q[0];
    case (sel_idx)
      SRC_SSF: pb_data = hold_data_q[1];
      SRC_SSH: pb_data = hold_data_q[2];
      default: pb_data = hold_data_q[0];
    endcase
  end

  // ---- per-source hold control ------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign drain[gi] = pb_we & (grant == 2'(gi));
    // A hold that is being written this cycle can take a new entry, which
    // lets a lone source stream at one entry per cycle.
    assign stall[gi] = hold_v_q[gi] & ~drain[gi];
    assign xfer[gi]  = bus.src_valid[gi] & ~stall[gi];
    // Refill wins over drain so drain+refill keeps the hold valid.
    assign hold_v_d[gi] = xfer[gi]  ? 1'b1 :
                          drain[gi] ? 1'b0 : hold_v_q[gi];
  end

  // Payload registers carry no reset; hold_v_q qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (xfer[i]) begin
        hold_data_q[i] <= bus.src_data[i];
      end
    end
  end

  // ---- pointer and frame counter ----------------------------------------
  assign rr_ptr_d   = pb_we ? rr_next(grant) : rr_ptr_q;
  assign frame_done = pb_we & (pix_count_q == LAST_PIX);

  always_comb begin
    pix_count_d = pix_count_q;
    if (pb_we) begin
      pix_count_d = frame_done ? '0 : pix_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hold_v_q    <= '0;
      rr_ptr_q    <= SRC_TF;
      pix_count_q <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      rr_ptr_q    <= rr_ptr_d;
      pix_count_q <= pix_count_d;
    end
  end

  // ---- outputs -----------------------------------------------------------
  assign bus.src_stall  = stall;
  assign bus.pb_we      = pb_we;
  assign bus.pb_data    = pb_data;
  assign bus.grant      = grant;
  assign bus.frame_done = frame_done;
  assign bus.pix_count  = pix_count_q;

endmodule

// File: tb/tb_sint_out_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_sint_out_rr_arb
// Directed bench for sint_out_rr_arb with a 5-pixel frame and 16-bit payload.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 units after the edge.
// ---------------------------------------------------------------------------
module tb_sint_out_rr_arb;

  localparam int DW = 16;
  localparam int NP = 5;
  localparam int CW = 3;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sint_out_rr_arb_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  sint_out_rr_arb #(
    .DATA_W     (DW),
    .NUM_PIXELS (NP),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Checks all outputs for one cycle; grant/data only matter with a write.
  task automatic check_cycle(input string tag, input logic we, input logic [1:0] g,
                             input logic [15:0] d, input logic fd,
                             input logic [2:0] cnt, input logic [2:0] st);
    check_eq({tag, ".we"},    32'(bus.pb_we),      32'(we));
    if (we) begin
      check_eq({tag, ".grant"}, 32'(bus.grant),    32'(g));
      check_eq({tag, ".data"},  32'(bus.pb_data),  32'(d));
    end
    check_eq({tag, ".fdone"}, 32'(bus.frame_done), 32'(fd));
    check_eq({tag, ".cnt"},   32'(bus.pix_count),  32'(cnt));
    check_eq({tag, ".stall"}, 32'(bus.src_stall),  32'(st));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k [3];
    logic [2:0] rel_stall [4];
    logic [1:0] g;

    bus.src_valid = 3'b000;
    bus.src_data  = '0;
    bus.pb_full   = 1'b0;

    // ---- reset state ----------------------------------------------------
    #2;
    check_cycle("rst", 1'b0, 2'd0, 16'h0, 1'b0, 3'd0, 3'b000);
    check_eq("rst.grant", 32'(bus.grant), 32'd0);
    step();
    check_cycle("rst2", 1'b0, 2'd0, 16'h0, 1'b0, 3'd0, 3'b000);
    rst_b = 1'b1;

    // ---- tf alone, data 1..12: writes one cycle behind, frame at 5/10 ---
    for (int c = 0; c < 14; c++) begin
      step();
      bus.src_valid    = (c < 12) ? 3'b001 : 3'b000;
      bus.src_data[0]  = 16'(c + 1);
      #1;
      check_cycle($sformatf("t1.c%0d", c), (c >= 1) && (c <= 12), 2'd0, 16'(c),
                  (c == 5) || (c == 10), 3'((c == 0) ? 0 : ((c - 1) % 5)), 3'b000);
    end

    // ---- all three valid every cycle; pointer starts at 1 --------------
    k = '{0, 0, 0};
    for (int c = 0; c < 10; c++) begin
      step();
      bus.src_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
        bus.src_data[i] = {8'(i + 1), 8'(k[i])};
      end
      #1;
      g = 2'(c % 3);
      check_cycle($sformatf("t2.c%0d", c), c >= 1, g, {8'(g + 1), 8'((c - 1) / 3)},
                  (c >= 1) && (((1 + c) % 5) == 4), 3'((c == 0) ? 2 : ((1 + c) % 5)),
                  (c == 0) ? 3'b000 : (3'b111 & ~(3'b001 << g)));
      for (int i = 0; i < 3; i++) begin
        if (!bus.src_stall[i]) k[i]++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t2.accepted%0d", i), 32'(k[i]), 32'd4);
    end

    // ---- holds full (A3,B3,C3), FIFO full for 20 cycles -----------------
    for (int c = 0; c < 20; c++) begin
      step();
      bus.src_valid = 3'b000;
      bus.pb_full   = 1'b1;
      #1;
      check_cycle($sformatf("t3.full%0d", c), 1'b0, 2'd0, 16'h0, 1'b0, 3'd1, 3'b111);
    end
    rel_stall = '{3'b101, 3'b001, 3'b000, 3'b000};
    for (int c = 0; c < 4; c++) begin
      step();
      bus.pb_full = 1'b0;
      #1;
      g = 2'((1 + c) % 3);
      check_cycle($sformatf("t3.rel%0d", c), c < 3, g, {8'(g + 1), 8'd3}, 1'b0,
                  3'(1 + c), rel_stall[c]);
    end

    // ---- build 2 held entries with pix_count=3, then async reset -------
    for (int c = 0; c < 5; c++) begin
      step();
      bus.src_valid   = (c < 4) ? 3'b001 : 3'b110;
      bus.src_data[0] = {8'h0A, 8'(c)};
      bus.src_data[1] = 16'h0B01;
      bus.src_data[2] = 16'h0C01;
      #1;
      check_cycle($sformatf("t4.c%0d", c), c >= 1, 2'd0, {8'h0A, 8'(c - 1)},
                  c == 1, 3'((c == 0) ? 4 : ((c + 3) % 5)), 3'b000);
    end
    step();
    bus.src_valid = 3'b000;
    #1;
    check_cycle("t4.pre", 1'b1, 2'd1, 16'h0B01, 1'b0, 3'd3, 3'b100);
    #1;
    rst_b = 1'b0;
    #1;
    check_cycle("t4.rst", 1'b0, 2'd0, 16'h0, 1'b0, 3'd0, 3'b000);
    check_eq("t4.rst.grant", 32'(bus.grant), 32'd0);
    step();
    check_cycle("t4.rsthold", 1'b0, 2'd0, 16'h0, 1'b0, 3'd0, 3'b000);
    #1;
    rst_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      check_cycle($sformatf("t4.post%0d", c), 1'b0, 2'd0, 16'h0, 1'b0, 3'd0, 3'b000);
    end
    step();
    bus.src_valid   = 3'b001;
    bus.src_data[0] = 16'h0D00;
    #1;
    check_cycle("t4.new0", 1'b0, 2'd0, 16'h0, 1'b0, 3'd0, 3'b000);
    step();
    bus.src_valid = 3'b000;
    #1;
    check_cycle("t4.new1", 1'b1, 2'd0, 16'h0D00, 1'b0, 3'd0, 3'b000);
    step();
    #1;
    check_cycle("t4.new2", 1'b0, 2'd0, 16'h0, 1'b0, 3'd1, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
